// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8N1 UART transmitter; define UART_TX_PARITY_EN for 8E1 framing
module uart_tx_serializer #(
  parameter int CLK_PER_BIT   = 104,
  parameter int COUNTER_WIDTH = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_busy,
  output logic       uart_tx
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  localparam logic [COUNTER_WIDTH-1:0] LP_LAST = COUNTER_WIDTH'(CLK_PER_BIT - 1);
  localparam logic [COUNTER_WIDTH-1:0] LP_ONE  = COUNTER_WIDTH'(1);

  state_t                   r_state, w_state_next;
  logic [COUNTER_WIDTH-1:0] r_cnt, w_cnt_next;
  logic [2:0]               r_idx, w_idx_next;
  logic [7:0]               r_shift, w_shift_next;
  logic                     r_tx, w_tx_next;
  logic                     r_busy, r_done, w_done_next;
  logic                     w_accept, w_bit_end;

  assign w_accept  = tx_valid && (r_state == S_IDLE);
  assign w_bit_end = (r_cnt == LP_LAST);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_done_next  = 1'b0;
    if (r_state != S_IDLE) begin
      w_cnt_next = w_bit_end ? '0 : r_cnt + LP_ONE;
    end
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_shift_next = tx_data;
          w_cnt_next   = '0;
          w_idx_next   = 3'd0;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_idx_next   = 3'd0;
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end else begin
            w_idx_next = r_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) w_state_next = S_STOP;
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Line level is computed from the next state so uart_tx changes on the same edge as the state.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_shift_next[w_idx_next];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_next = ^w_shift_next;
`endif
      default:  w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
      r_busy  <= (w_state_next != S_IDLE);
      r_done  <= w_done_next;
    end
  end

  assign tx_ready = (r_state == S_IDLE);
  assign tx_done  = r_done;
  assign tx_busy  = r_busy;
  assign uart_tx  = r_tx;

endmodule
